// File: rtl/idct_zigzag_block_loader.sv
// Zigzag-order coefficient loader for the IDCT stream wrapper. Two ping-pong
// 8x8 banks are filled from zigzag beats and drained as raster rows.
module idct_zigzag_block_loader #(
  parameter int COEF_W = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [COEF_W-1:0]     master_tdata,
  input  logic                  master_tvalid,
  input  logic                  master_tlast,
  output logic                  slave_tready,
  output logic [8*COEF_W-1:0]   slave_tdata,
  output logic                  slave_tvalid,
  input  logic                  master_tready,
  output logic                  tlast_err
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic [COEF_W-1:0] r_mem [2][64];
  logic [63:0]       r_valid [2];
  logic [1:0]        r_full;
  logic [5:0]        r_widx;
  logic              r_wb;
  logic [2:0]        r_rrow;
  logic              r_rb;
  state_t            r_state;

  logic              w_accept;
  logic              w_wrDone;
  logic [5:0]        w_wrPos;

  assign slave_tready = !r_full[r_wb];
  assign w_accept     = master_tvalid && slave_tready;
  assign w_wrPos      = ZZ[r_widx];
  assign w_wrDone     = master_tlast || (r_widx == 6'd63);

  // Positions never written in the current block read back as zero.
  function automatic logic [8*COEF_W-1:0] rowData(input logic bank, input logic [2:0] row);
    logic [8*COEF_W-1:0] v;
    logic [5:0]          idx;
    v = '0;
    for (int c = 0; c < 8; c++) begin
      idx = {row, 3'(c)};
      if (r_valid[bank][idx]) v[COEF_W*c +: COEF_W] = r_mem[bank][idx];
    end
    return v;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset && w_accept) r_mem[r_wb][w_wrPos] <= master_tdata;
  end

  // Write and read sides always touch different banks, so their updates to
  // the full flags and valid masks never collide in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_full       <= '0;
      r_valid[0]   <= '0;
      r_valid[1]   <= '0;
      r_widx       <= '0;
      r_wb         <= 1'b0;
      r_rrow       <= '0;
      r_rb         <= 1'b0;
      r_state      <= S_IDLE;
      slave_tdata  <= '0;
      slave_tvalid <= 1'b0;
      tlast_err    <= 1'b0;
    end else begin
      tlast_err <= w_accept && (r_widx == 6'd63) && !master_tlast;

      if (w_accept) begin
        r_valid[r_wb][w_wrPos] <= 1'b1;
        if (w_wrDone) begin
          r_full[r_wb] <= 1'b1;
          r_wb         <= !r_wb;
          r_widx       <= '0;
        end else begin
          r_widx <= r_widx + 6'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (r_full[r_rb]) begin
            slave_tdata  <= rowData(r_rb, 3'd0);
            slave_tvalid <= 1'b1;
            r_rrow       <= '0;
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (master_tready) begin
            if (r_rrow == 3'd7) begin
              r_full[r_rb]  <= 1'b0;
              r_valid[r_rb] <= '0;
              r_rb          <= !r_rb;
              r_rrow        <= '0;
              // Chain straight into the other bank to avoid an output bubble.
              if (r_full[!r_rb]) begin
                slave_tdata <= rowData(!r_rb, 3'd0);
              end else begin
                slave_tvalid <= 1'b0;
                r_state      <= S_IDLE;
              end
            end else begin
              r_rrow      <= r_rrow + 3'd1;
              slave_tdata <= rowData(r_rb, r_rrow + 3'd1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_zigzag_block_loader.sv
// Directed bench for the zigzag block loader: table-driven raster rows plus
// hand-written ping-pong, backpressure, missing-tlast and reset sequences.
module tb_idct_zigzag_block_loader;

  localparam int COEF_W = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [11:0]   masterTdata = '0;
  logic          masterTvalid = 1'b0;
  logic          masterTlast = 1'b0;
  logic          slaveTready;
  logic [95:0]   slaveTdata;
  logic          slaveTvalid;
  logic          masterTready = 1'b0;
  logic          tlastErr;

  typedef struct {
    int holdCycles;
    int e [8];
  } rowVec_t;

  rowVec_t     tbl [8];
  int          compared = 0;
  int          failed = 0;
  int          errPulses = 0;
  logic        collectRows = 1'b0;
  logic        readyDropped = 1'b0;
  logic [95:0] rowQ [$];
  logic        heldValid = 1'b0;
  logic [95:0] heldData = '0;

  idct_zigzag_block_loader #(.COEF_W(COEF_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .master_tdata  (masterTdata),
    .master_tvalid (masterTvalid),
    .master_tlast  (masterTlast),
    .slave_tready  (slaveTready),
    .slave_tdata   (slaveTdata),
    .slave_tvalid  (slaveTvalid),
    .master_tready (masterTready),
    .tlast_err     (tlastErr)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor runs on the falling edge so DUT outputs and bench inputs are stable.
  always @(negedge clock) begin
    if (tlastErr) errPulses++;
    if (collectRows && slaveTvalid && masterTready) rowQ.push_back(slaveTdata);
    if (collectRows && !slaveTready) readyDropped = 1'b1;
    if (heldValid && slaveTvalid) checkOutput("held tdata stable", slaveTdata, heldData);
    heldValid = slaveTvalid && !masterTready;
    heldData  = slaveTdata;
  end

  function automatic logic [95:0] makeRow(input int base, input int r);
    logic [95:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[12*c +: 12] = 12'(base + tbl[r].e[c]);
    return v;
  endfunction

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [11:0] data, input logic last);
    int waitCycles;
    waitCycles   = 0;
    masterTdata  = data;
    masterTlast  = last;
    masterTvalid = 1'b1;
    while (!slaveTready && waitCycles < 500) begin
      @(posedge clock); #1;
      waitCycles++;
    end
    if (!slaveTready) begin
      compared++;
      failed++;
      $display("[TB] FAIL beat accept timeout: got tready=0, expected tready=1");
      masterTvalid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    masterTvalid = 1'b0;
    masterTlast  = 1'b0;
  endtask

  task automatic consumeRow(output logic [95:0] data);
    int waitCycles;
    waitCycles = 0;
    while (!slaveTvalid && waitCycles < 500) begin
      @(posedge clock); #1;
      waitCycles++;
    end
    if (!slaveTvalid) begin
      compared++;
      failed++;
      $display("[TB] FAIL row wait timeout: got tvalid=0, expected tvalid=1");
      data = '0;
      return;
    end
    data = slaveTdata;
    masterTready = 1'b1;
    @(posedge clock); #1;
    masterTready = 1'b0;
  endtask

  task automatic feedBlock(input int base, input logic withLast);
    for (int k = 0; k < 64; k++) applyStimulus(12'(base + k), withLast && (k == 63));
  endtask

  task automatic drainTable(input string name, input int base);
    logic [95:0] d;
    for (int r = 0; r < 8; r++) begin
      consumeRow(d);
      checkOutput($sformatf("%s row%0d", name, r), d, makeRow(base, r));
    end
  endtask

  task automatic drainSparse(input string name, input logic [95:0] row0);
    logic [95:0] d;
    for (int r = 0; r < 8; r++) begin
      consumeRow(d);
      checkOutput($sformatf("%s row%0d", name, r), d, (r == 0) ? row0 : 96'h0);
    end
  endtask

  initial begin
    logic [95:0] d;
    int          pulsesBefore;
    int          waitCycles;

    // Inverse zigzag: raster row r, column c holds zigzag beat e[c].
    tbl[0].holdCycles = 0; tbl[0].e = '{ 0,  1,  5,  6, 14, 15, 27, 28};
    tbl[1].holdCycles = 3; tbl[1].e = '{ 2,  4,  7, 13, 16, 26, 29, 42};
    tbl[2].holdCycles = 0; tbl[2].e = '{ 3,  8, 12, 17, 25, 30, 41, 43};
    tbl[3].holdCycles = 1; tbl[3].e = '{ 9, 11, 18, 24, 31, 40, 44, 53};
    tbl[4].holdCycles = 0; tbl[4].e = '{10, 19, 23, 32, 39, 45, 52, 54};
    tbl[5].holdCycles = 5; tbl[5].e = '{20, 22, 33, 38, 46, 51, 55, 60};
    tbl[6].holdCycles = 0; tbl[6].e = '{21, 34, 37, 47, 50, 56, 59, 61};
    tbl[7].holdCycles = 2; tbl[7].e = '{35, 36, 48, 49, 57, 58, 62, 63};

    doReset();
    checkOutput("reset tvalid", 96'(slaveTvalid), 96'h0);
    checkOutput("reset tdata", slaveTdata, 96'h0);
    checkOutput("reset tlast_err", 96'(tlastErr), 96'h0);
    checkOutput("reset tready", 96'(slaveTready), 96'h1);

    $display("[TB] zigzag order block");
    feedBlock(0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      repeat (tbl[i].holdCycles) begin
        @(posedge clock); #1;
      end
      consumeRow(d);
      checkOutput($sformatf("zigzag row%0d", i), d, makeRow(0, i));
    end
    checkOutput("zigzag no tlast_err", 96'(errPulses), 96'h0);

    $display("[TB] end-of-block zero fill");
    applyStimulus(12'h7FF, 1'b1);
    drainSparse("eob 7FF", 96'h7FF);
    applyStimulus(12'h800, 1'b1);
    drainSparse("eob reused bank", 96'h800);

    $display("[TB] ping-pong streaming");
    doReset();
    rowQ.delete();
    readyDropped = 1'b0;
    masterTready = 1'b1;
    collectRows  = 1'b1;
    for (int b = 0; b < 3; b++) feedBlock(b << 8, 1'b1);
    waitCycles = 0;
    while (rowQ.size() < 24 && waitCycles < 200) begin
      @(posedge clock); #1;
      waitCycles++;
    end
    collectRows  = 1'b0;
    masterTready = 1'b0;
    checkOutput("pingpong row count", 96'(rowQ.size()), 96'd24);
    checkOutput("pingpong tready held", 96'(readyDropped), 96'h0);
    for (int i = 0; i < 24 && i < rowQ.size(); i++)
      checkOutput($sformatf("pingpong row%0d", i), rowQ[i], makeRow((i / 8) << 8, i % 8));

    $display("[TB] backpressure with both banks full");
    doReset();
    feedBlock(0, 1'b1);
    checkOutput("bp tready after A", 96'(slaveTready), 96'h1);
    feedBlock(12'h200, 1'b1);
    checkOutput("bp tready after B", 96'(slaveTready), 96'h0);
    repeat (5) begin
      @(posedge clock); #1;
    end
    masterTready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("bp tvalid row%0d", i), 96'(slaveTvalid), 96'h1);
      checkOutput($sformatf("bp data row%0d", i), slaveTdata,
                  (i < 8) ? makeRow(0, i) : makeRow(12'h200, i - 8));
      @(posedge clock); #1;
      if (i == 6) checkOutput("bp tready before A7", 96'(slaveTready), 96'h0);
      if (i == 7) checkOutput("bp tready after A7", 96'(slaveTready), 96'h1);
    end
    masterTready = 1'b0;
    checkOutput("bp idle after B", 96'(slaveTvalid), 96'h0);

    $display("[TB] missing tlast");
    doReset();
    pulsesBefore = errPulses;
    for (int k = 0; k < 63; k++) applyStimulus(12'(12'hF00 + k), 1'b0);
    checkOutput("no err before beat 63", 96'(tlastErr), 96'h0);
    applyStimulus(12'hF3F, 1'b0);
    checkOutput("tlast_err pulse", 96'(tlastErr), 96'h1);
    @(posedge clock); #1;
    checkOutput("tlast_err one cycle", 96'(tlastErr), 96'h0);
    drainTable("no-tlast", 12'hF00);
    checkOutput("tlast_err pulse count", 96'(errPulses - pulsesBefore), 96'd1);

    $display("[TB] reset mid-operation");
    doReset();
    for (int k = 0; k < 30; k++) applyStimulus(12'(k + 1), 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("mid-load reset tvalid", 96'(slaveTvalid), 96'h0);
    checkOutput("mid-load reset tready", 96'(slaveTready), 96'h1);
    applyStimulus(12'h055, 1'b1);
    drainSparse("after load reset", 96'h055);
    feedBlock(0, 1'b1);
    for (int r = 0; r < 3; r++) consumeRow(d);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("mid-drain reset tvalid", 96'(slaveTvalid), 96'h0);
    applyStimulus(12'h0AA, 1'b0);
    applyStimulus(12'h0BB, 1'b1);
    drainSparse("after drain reset", {72'h0, 12'h0BB, 12'h0AA});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/idct_zigzag_block_loader.md
Name: idct_zigzag_block_loader

Overview:
- Upstream feeder for the IDCT AXI-stream wrapper.
- Accepts one signed 12-bit coefficient per beat in JPEG zigzag order. Blocks end at 64 beats or at an early tlast (end-of-block), and missing positions are zero-filled.
- Emits each completed 8x8 block as 8 raster-order rows of 8x12 bits (96-bit beats), which is the wrapper's input format.
- Two ping-pong block banks let one block load while the previous one drains.

Parameters:
- COEF_W, 12, coefficient width in bits. The output row is 8*COEF_W bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- master_tdata  in  COEF_W  coefficient, two's complement, zigzag order
- master_tvalid  in  1  input beat valid
- master_tlast  in  1  last coefficient of the block (EOB)
- slave_tready  out  1  input beat accepted when master_tvalid & slave_tready
- slave_tdata  out  8*COEF_W  raster row; element c at bits [COEF_W*c+COEF_W-1 : COEF_W*c]
- slave_tvalid  out  1  output row valid
- master_tready  in  1  downstream ready; row transferred when slave_tvalid & master_tready
- tlast_err  out  1  one-cycle pulse when the 64th beat arrives without master_tlast

Behaviour:
Reset and idle state:
- Reset values: slave_tvalid=0, slave_tdata=0, tlast_err=0, slave_tready=1.
- Both banks empty, all valid masks cleared, write counter widx=0, wb=0, row counter rrow=0, rb=0.
- Reset mid-block discards all partial and full blocks.

Storage:
- Bank b (b=0,1) holds 64 entries of COEF_W bits, a 64-bit valid mask, and a full flag.

Write side:
- slave_tready = !full[wb].
- On an accepted beat:
  - bank[wb][ZZ[widx]] <= master_tdata
  - valid[wb][ZZ[widx]] <= 1
- Block completes when master_tlast is set, or when widx==63.
- On completion: full[wb] <= 1, wb toggles, widx <= 0. Otherwise widx increments.
- tlast_err pulses the cycle after accepting widx==63 with master_tlast=0.
- Beats after an early tlast start the next block.

Zigzag table (ZZ[k] = raster index, k=0..63):
- 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,
- 12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,
- 35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
- 58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63

Read side:
- Two states:
  - IDLE: waits for full[rb].
  - SEND: slave_tvalid=1 while rrow 0..7.
- Element c of row r is bank[rb][8r+c] if valid[rb][8r+c] is set, otherwise 0.
- Output is registered:
  - slave_tdata/slave_tvalid are updated on the clock edge after the block completes, or after the prior row is accepted.
  - Latency from the final accepted input beat to the first slave_tvalid: 1 cycle (when the read bank is free).
- While slave_tvalid & !master_tready, slave_tdata is held stable.
- On acceptance of row 7:
  - full[rb] <= 0, valid[rb] <= 0, rb toggles, rrow <= 0.
  - If the other bank is already full, its row 0 is presented on the next cycle with no bubble.
  - Otherwise return to IDLE with slave_tvalid=0.

Boundary conditions:
- Same-cycle bank release and write-side stall: slave_tready rises the following cycle, because the full flag is registered.
- Both banks full: slave_tready=0. No input is lost.
- A block can complete on the write side in the same cycle the read side frees the other bank; both updates must take effect.
- Sustained throughput with master_tready=1: 64 input beats per 8 output rows. The read side never starves the write side.

Test Plan:
- Zigzag order: feed one block with beat k carrying value k, tlast on k=63. Required response:
  - row 0 elements = 0,1,5,6,14,15,27,28
  - row 7 elements = 35,36,48,49,57,58,62,63
  - tlast_err=0
- EOB zero-fill: feed one beat 0x7FF with tlast. Required response:
  - row 0 = {0,...,0,0x7FF}, i.e. element 0 = 0x7FF
  - rows 1-7 = 0
  - the next block in the same bank is also clean (valid mask cleared)
- Ping-pong: feed three back-to-back 64-beat blocks with master_tready=1. Required response:
  - slave_tready never deasserts
  - 24 rows emitted
  - no idle cycle between blocks 1 and 2 on the output
- Backpressure: hold master_tready=0 and feed blocks. Required response:
  - slave_tready drops after the 128th accepted beat
  - slave_tdata stays stable
  - on release, both blocks drain in order and slave_tready returns 1 cycle after row 7 of block A is accepted
- Missing tlast: feed 64 beats with tlast=0. Required response:
  - tlast_err pulses exactly once, the cycle after beat 63
  - the block is still emitted
- Reset mid-operation: assert reset after 30 beats and mid-drain at row 3. Required response:
  - slave_tvalid=0 the next cycle
  - a subsequent block emits correctly starting at row 0
